character_recognition: RTL and testbench



---
 rtl/character_recognition.sv | 51 +++++
 tb/tb_character_recognition.sv | 116 +++++++++++
 2 files changed

// File: rtl/character_recognition.sv
// character_recognition: serial matcher for "OPENWINDOW"/"CLOSEWINDOW" driving a registered window flag.
// The "WINDOW" tail is shared by both commands; dir remembers which word led into it.
module character_recognition (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ascii,
    output logic       window
);
    typedef enum logic [3:0] {
        IDLE, S_O, S_OP, S_OPE, S_C, S_CL, S_CLO, S_CLOS,
        S_STEM, S_W, S_WI, S_WIN, S_WIND, S_WINDO
    } state_t;
    state_t state;
    state_t start;
    logic   dir;
    // on any mismatch the current character may itself begin a new word
    assign start = ascii == "O" ? S_O : ascii == "C" ? S_C : IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir    <= 1'b0;
            window <= 1'b0;
        end else begin
            case (state)
                S_O:    state <= ascii == "P" ? S_OP : start;
                S_OP:   state <= ascii == "E" ? S_OPE : start;
                S_OPE: begin
                    state <= ascii == "N" ? S_STEM : start;
                    if (ascii == "N") dir <= 1'b1;
                end
                S_C:    state <= ascii == "L" ? S_CL : start;
                S_CL:   state <= ascii == "O" ? S_CLO : start;
                S_CLO:  state <= ascii == "S" ? S_CLOS : start;
                S_CLOS: begin
                    state <= ascii == "E" ? S_STEM : start;
                    if (ascii == "E") dir <= 1'b0;
                end
                S_STEM: state <= ascii == "W" ? S_W : start;
                S_W:    state <= ascii == "I" ? S_WI : start;
                S_WI:   state <= ascii == "N" ? S_WIN : start;
                S_WIN:  state <= ascii == "D" ? S_WIND : start;
                S_WIND: state <= ascii == "O" ? S_WINDO : start;
                S_WINDO: begin
                    state <= ascii == "W" ? IDLE : start;
                    if (ascii == "W") window <= dir;
                end
                default: state <= start;
            endcase
        end
    end
endmodule

// File: tb/tb_character_recognition.sv
// tb_character_recognition: directed and random character streams checked against a prefix-tracking word model.
module tb_character_recognition;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic       window;
    int         checks = 0;
    int         errors = 0;
    int         m_len = 0;
    bit         m_open = 1'b0;
    logic       m_window = 1'b0;
    character_recognition dut (
        .clk(clk),
        .rst_n(rst_n),
        .ascii(ascii),
        .window(window)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_len = 0;
        m_window = 1'b0;
    endtask
    // the model tracks how much of the chosen word has been seen so far
    task automatic model_step(input logic [7:0] c);
        string target;
        target = m_open ? "OPENWINDOW" : "CLOSEWINDOW";
        if (m_len > 0 && c == target[m_len]) begin
            m_len++;
            if (m_len == target.len()) begin
                m_window = m_open;
                m_len = 0;
            end
        end else if (c == "O") begin
            m_open = 1'b1;
            m_len = 1;
        end else if (c == "C") begin
            m_open = 1'b0;
            m_len = 1;
        end else begin
            m_len = 0;
        end
    endtask
    task automatic send(input logic [7:0] c, input string tag);
        ascii = c;
        @(posedge clk);
        #1;
        model_step(c);
        check(tag, window, m_window);
    endtask
    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) send(s[i], tag);
    endtask
    initial begin
        string pool;
        pool = "OPENWICLSDXo";
        #30;
        #2 rst_n = 1'b1;
        model_reset();
        check("reset", window, 1'b0);
        send_str("OPENWI", "midword");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("midword_rst", window, 1'b0);
        #1 rst_n = 1'b1;
        send_str("NDOW", "after_rst");
        check("after_rst_const", window, 1'b0);
        send_str("OPENWINDO", "open_pre");
        send("W", "open_w");
        check("open_const", window, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h00, "open_hold");
        send_str("CLOSEWINDOW", "close");
        check("close_const", window, 1'b0);
        send_str("CLOSEWINDOW", "close_again");
        send_str("OPXNWINDOW", "opx");
        send_str("OOPENWINDOW", "oopen");
        check("oopen_const", window, 1'b1);
        send_str("OPENWINDOWOPENWINDOW", "reopen");
        send_str("OPENWINDOCLOSEWINDOW", "openc");
        check("openc_const", window, 1'b0);
        send_str("OPECLOSEWINDOW", "opec");
        send_str("openwindow", "lower");
        send_str("OPEN WINDOW", "space");
        send_str("OPEN", "gap");
        send(8'h00, "gap");
        send_str("WINDOW", "gap");
        check("gap_const", window, 1'b0);
        send_str("CLOPENWINDOW", "clopen");
        send_str("OPENWINDOWCLOSEWINDOW", "b2b");
        send_str("WINDOPENWINDOW", "windop");
        send_str("OPENWINDOW", "async_pre");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("async_rst", window, 1'b0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) send_str("OPENWINDOW", "rnd_open");
            else if (r == 1) send_str("CLOSEWINDOW", "rnd_close");
            else begin
                int k;
                k = $urandom_range(0, pool.len() - 1);
                send(pool[k], "rnd_char");
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
